nz_mask_gen: RTL

- Multi-lane successor to the single-byte zero-mask mapper in the masked round-based AES datapath.
- Takes raw random words from the TRNG/PRNG side and guarantees every lane delivered to the masking logic is nonzero.
- Each zero lane is replaced by the current state of a per-lane nonzero Galois LFSR.
- Adds valid/ready handshaking, a one-entry output register, and a saturating zero-event counter.

---
 rtl/nz_mask_gen_pkg.sv | 32 +++
 rtl/nz_mask_gen_lane.sv | 82 ++++++++
 rtl/nz_mask_gen.sv | 96 +++++++++
 3 files changed

// File: rtl/nz_mask_gen_pkg.sv
// Shared constants and helpers for the nonzero mask generator.
// The optional repetition health test is enabled with the NZ_HEALTH_EN macro.
package nz_mask_pkg;

    localparam int unsigned      MAX_W    = 32;
    localparam logic [7:0]       DEF_POLY = 8'h1D;
    localparam logic [7:0]       DEF_SEED = 8'hA5;
    localparam logic [MAX_W-1:0] ONE      = 1;

    // One Galois step on the low w bits of s; callers truncate the result to their width.
    function automatic logic [MAX_W-1:0] lfsr_step(
        input logic [MAX_W-1:0] s,
        input logic [MAX_W-1:0] poly,
        input int               w
    );
        logic [MAX_W-1:0] top;
        logic [MAX_W-1:0] mask;
        top  = ONE << (w - 1);
        mask = (top << 1) - ONE;
        return ((s << 1) & mask) ^ (((s & top) != '0) ? (poly & mask) : '0);
    endfunction

    function automatic logic [7:0] popcount(input logic [63:0] v);
        logic [7:0] n;
        n = '0;
        for (int b = 0; b < 64; b++) begin
            n = n + {7'd0, v[b]};
        end
        return n;
    endfunction

endpackage

// File: rtl/nz_mask_gen_lane.sv
// One mask lane: zero detect, per-lane nonzero LFSR and replacement mux.
// With NZ_HEALTH_EN defined, also a sticky repetition-count test on the raw word.
module nz_lane
    import nz_mask_pkg::*;
#(
    parameter int unsigned       WIDTH     = 8,
    parameter logic [WIDTH-1:0]  POLY      = DEF_POLY,
    parameter logic [WIDTH-1:0]  SEED      = DEF_SEED,
    parameter int unsigned       REP_LIMIT = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] raw_i,
    input  logic             accept_i,
    output logic [WIDTH-1:0] word_o,
    output logic             zero_o,
    output logic             health_fail_o
);

    if (WIDTH < 2 || WIDTH > MAX_W || REP_LIMIT < 1) begin : g_bad_cfg
        $error("nz_lane: unsupported WIDTH or REP_LIMIT");
    end

    logic [WIDTH-1:0] lfsr_q;
    logic [WIDTH-1:0] lfsr_d;

    assign zero_o = (raw_i == '0);
    assign word_o = zero_o ? lfsr_q : raw_i;
    assign lfsr_d = (accept_i && zero_o)
                  ? WIDTH'(lfsr_step(MAX_W'(lfsr_q), MAX_W'(POLY), int'(WIDTH)))
                  : lfsr_q;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr_q <= SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

`ifdef NZ_HEALTH_EN
    localparam int unsigned    RUN_W   = $clog2(REP_LIMIT + 1);
    localparam logic [RUN_W-1:0] RUN_ONE = RUN_W'(1);
    localparam logic [RUN_W-1:0] RUN_LIM = RUN_W'(REP_LIMIT);

    logic [WIDTH-1:0] prev_q;
    logic [RUN_W-1:0] run_q;
    logic [RUN_W-1:0] run_d;
    logic             seen_q;
    logic             fail_q;

    // The run saturates at the limit so a long repeat cannot wrap back below it.
    always_comb begin
        run_d = RUN_ONE;
        if (seen_q && raw_i == prev_q) begin
            run_d = (run_q == RUN_LIM) ? run_q : run_q + RUN_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            prev_q <= '0;
            run_q  <= '0;
            seen_q <= 1'b0;
            fail_q <= 1'b0;
        end else if (accept_i) begin
            prev_q <= raw_i;
            run_q  <= run_d;
            seen_q <= 1'b1;
            if (run_d >= RUN_LIM) begin
                fail_q <= 1'b1;
            end
        end
    end

    assign health_fail_o = fail_q;
`else
    assign health_fail_o = 1'b0;
`endif

endmodule

// File: rtl/nz_mask_gen.sv
// Multi-lane nonzero mask generator: valid/ready handshake, one output register,
// saturating zero-event counter. Optional repetition health test under NZ_HEALTH_EN.
module nz_mask_gen
    import nz_mask_pkg::*;
#(
    parameter int unsigned      WIDTH     = 8,
    parameter int unsigned      LANES     = 4,
    parameter logic [WIDTH-1:0] POLY      = DEF_POLY,
    parameter logic [WIDTH-1:0] SEED      = DEF_SEED,
    parameter int unsigned      CNT_W     = 16,
    parameter int unsigned      REP_LIMIT = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [LANES*WIDTH-1:0] in_data,
    input  logic                   in_valid,
    output logic                   in_ready,
    output logic [LANES*WIDTH-1:0] out_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    input  logic                   cnt_clr,
    output logic [CNT_W-1:0]       zero_cnt,
    output logic [LANES-1:0]       health_fail
);

    if (LANES < 1 || LANES > 64 || CNT_W < 1) begin : g_bad_cfg
        $error("nz_mask_gen: unsupported LANES or CNT_W");
    end

    localparam int unsigned      SUM_W   = CNT_W + 8;
    localparam logic [SUM_W-1:0] CNT_MAX = {8'd0, {CNT_W{1'b1}}};

    logic [LANES*WIDTH-1:0] lane_word;
    logic [LANES-1:0]       lane_zero;
    logic [LANES*WIDTH-1:0] out_data_q;
    logic                   out_valid_q;
    logic                   accept;
    logic [CNT_W-1:0]       zero_cnt_q;
    logic [CNT_W-1:0]       zero_cnt_d;
    logic [SUM_W-1:0]       cnt_sum;

    assign in_ready = !out_valid_q || out_ready;
    assign accept   = in_valid && in_ready;

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        localparam logic [WIDTH-1:0] SEED_X    = SEED ^ WIDTH'(i);
        localparam logic [WIDTH-1:0] LANE_SEED = (SEED_X == '0) ? {{(WIDTH-1){1'b0}}, 1'b1} : SEED_X;

        nz_lane #(
            .WIDTH     (WIDTH),
            .POLY      (POLY),
            .SEED      (LANE_SEED),
            .REP_LIMIT (REP_LIMIT)
        ) u_lane (
            .clk           (clk),
            .rst           (rst),
            .raw_i         (in_data[i*WIDTH +: WIDTH]),
            .accept_i      (accept),
            .word_o        (lane_word[i*WIDTH +: WIDTH]),
            .zero_o        (lane_zero[i]),
            .health_fail_o (health_fail[i])
        );
    end

    // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        cnt_sum    = {8'd0, zero_cnt_q} + SUM_W'(popcount(64'(lane_zero)));
        zero_cnt_d = zero_cnt_q;
        if (cnt_clr) begin
            zero_cnt_d = '0;
        end else if (accept) begin
            zero_cnt_d = (cnt_sum > CNT_MAX) ? '1 : cnt_sum[CNT_W-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            zero_cnt_q  <= '0;
        end else begin
            if (accept) begin
                out_valid_q <= 1'b1;
                out_data_q  <= lane_word;
            end else if (out_ready) begin
                out_valid_q <= 1'b0;
            end
            zero_cnt_q <= zero_cnt_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign zero_cnt  = zero_cnt_q;

endmodule
